bg_tile_fetcher: RTL and testbench

Parametrised background line fetcher. For each display line it walks one row of the character map in external 16-bit SRAM, fetches each referenced tile's 4bpp pattern row, and streams 8 palette-tagged pixels per tile on a valid/ready port. It sits in the clk100 domain between the SRAM port and the pixel-domain line FIFO. It adds per-tile palettes, an optional horizontal flip, backpressure and a line abort.

---
 rtl/bg_tile_fetcher.sv | 185 ++++++++++++++++++
 tb/tb_bg_tile_fetcher.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_tile_fetcher.sv
// Background line fetcher: walks one character-map row in 16-bit SRAM, fetches each tile's
// 4bpp pattern row and streams palette-tagged pixels. Define BG_HFLIP_EN for per-tile hflip.
module bg_tile_fetcher #(
    parameter int unsigned COLS      = 40,
    parameter int unsigned MAP_SHIFT = 6,
    parameter logic [17:0] MAP_BASE  = 18'h00000,
    parameter logic [17:0] TILE_BASE = 18'h10000
) (
    input  logic        clk100,
    input  logic        rstN,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  lineY,
    output logic        busy,
    output logic        done,
    output logic [7:0]  px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [17:0] ram_addr,
    input  logic [15:0] ram_din,
    output logic        ram_ce,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        ram_lb,
    output logic        ram_hb
);

    typedef enum logic [2:0] {StIdle, StMap, StTw0, StTw1, StEmit, StDone} state_e;

    localparam logic [9:0] LastCol = 10'(COLS - 1);

    state_e      state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [17:0] map_addr_q, map_addr_d;
    logic [17:0] ram_addr_q, ram_addr_d;
    logic [9:0]  col_q, col_d;
    logic [2:0]  pix_q, pix_d;
    logic [3:0]  pal_q, pal_d;
    logic [15:0] w0_q, w0_d;
    logic [15:0] w1_q, w1_d;
    logic        busy_q, busy_d;
    logic        ce_q, ce_d;
    logic [2:0]  idx;
    logic [31:0] pattern;

`ifdef BG_HFLIP_EN
    logic hflip_q, hflip_d;
    logic unused_din;
    assign unused_din = ^ram_din[15:14];
    assign idx = pix_q ^ {3{hflip_q}};
`else
    logic unused_din;
    assign unused_din = ^{ram_din[15:14], ram_din[9]};
    assign idx = pix_q;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        map_addr_d = map_addr_q;
        ram_addr_d = ram_addr_q;
        col_d      = col_q;
        pix_d      = pix_q;
        pal_d      = pal_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        busy_d     = busy_q;
        ce_d       = ce_q;
`ifdef BG_HFLIP_EN
        hflip_d    = hflip_q;
`endif
        px_valid   = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    row_d      = lineY[2:0];
                    map_addr_d = MAP_BASE + (18'(lineY[9:3]) << MAP_SHIFT);
                    ram_addr_d = map_addr_d;
                    col_d      = '0;
                    busy_d     = 1'b1;
                    ce_d       = 1'b1;
                    state_d    = StMap;
                end
            end
            StMap: begin
                pal_d      = ram_din[13:10];
`ifdef BG_HFLIP_EN
                hflip_d    = ram_din[9];
`endif
                ram_addr_d = TILE_BASE + 18'({ram_din[8:0], row_q, 1'b0});
                state_d    = StTw0;
            end
            StTw0: begin
                w0_d       = ram_din;
                ram_addr_d = ram_addr_q + 18'd1;
                state_d    = StTw1;
            end
            StTw1: begin
                w1_d    = ram_din;
                pix_d   = '0;
                state_d = StEmit;
            end
            StEmit: begin
                px_valid = 1'b1;
                if (px_ready) begin
                    pix_d = pix_q + 3'd1;
                    if (pix_q == 3'd7) begin
                        if (col_q == LastCol) begin
                            state_d = StDone;
                        end else begin
                            col_d      = col_q + 10'd1;
                            map_addr_d = map_addr_q + 18'd1;
                            ram_addr_d = map_addr_q + 18'd1;
                            state_d    = StMap;
                        end
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                ce_d    = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any acceptance or completion in the same cycle.
        if (abort && state_q != StIdle) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            ce_d       = 1'b0;
            done       = 1'b0;
            ram_addr_d = ram_addr_q;
        end
    end

    always_ff @(posedge clk100 or negedge rstN) begin
        if (!rstN) begin
            state_q    <= StIdle;
            row_q      <= '0;
            map_addr_q <= '0;
            ram_addr_q <= '0;
            col_q      <= '0;
            pix_q      <= '0;
            pal_q      <= '0;
            w0_q       <= '0;
            w1_q       <= '0;
            busy_q     <= 1'b0;
            ce_q       <= 1'b0;
`ifdef BG_HFLIP_EN
            hflip_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            map_addr_q <= map_addr_d;
            ram_addr_q <= ram_addr_d;
            col_q      <= col_d;
            pix_q      <= pix_d;
            pal_q      <= pal_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            busy_q     <= busy_d;
            ce_q       <= ce_d;
`ifdef BG_HFLIP_EN
            hflip_q    <= hflip_d;
`endif
        end
    end

    // Pixel k sits at bits [31-4k -: 4] of {w0,w1}; {~k,2'b11} is that top bit.
    assign pattern  = {w0_q, w1_q};
    assign px_data  = px_valid ? {pal_q, pattern[{~idx, 2'b11} -: 4]} : 8'h00;
    assign busy     = busy_q;
    assign ram_addr = ram_addr_q;
    assign ram_ce   = ce_q;
    assign ram_oe   = ce_q;
    assign ram_we   = 1'b0;
    assign ram_lb   = 1'b1;
    assign ram_hb   = 1'b1;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher: a formula SRAM feeds a 40-column instance and a
// 2-column instance whose map base sits at the top of the address space.
module tb_bg_tile_fetcher;

    logic        clk100 = 1'b0;
    logic        rstN;
    logic        start, abort, px_ready, sel;
    logic [9:0]  lineY;

    logic        busy, done, px_valid, ram_ce, ram_oe, ram_we, ram_lb, ram_hb;
    logic [7:0]  px_data;
    logic [17:0] ram_addr;
    logic [15:0] ram_din;

    logic        w_busy, w_done, w_px_valid, w_ce, w_oe, w_we, w_lb, w_hb;
    logic [7:0]  w_px_data;
    logic [17:0] w_ram_addr;
    logic [15:0] w_ram_din;

    logic        m_start, w_start;
    logic        o_valid, o_done, o_busy, o_ce;
    logic [7:0]  o_data;
    logic [17:0] o_addr;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  cap_q[$];
    logic [3:0]  flip_exp [8];

    always #5 clk100 = ~clk100;

    bg_tile_fetcher u_dut (
        .clk100(clk100), .rstN(rstN), .start(m_start), .abort(abort), .lineY(lineY),
        .busy(busy), .done(done), .px_data(px_data), .px_valid(px_valid),
        .px_ready(px_ready), .ram_addr(ram_addr), .ram_din(ram_din), .ram_ce(ram_ce),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
    );

    bg_tile_fetcher #(.COLS(2), .MAP_BASE(18'h3FFFF)) u_wrap (
        .clk100(clk100), .rstN(rstN), .start(w_start), .abort(abort), .lineY(lineY),
        .busy(w_busy), .done(w_done), .px_data(w_px_data), .px_valid(w_px_valid),
        .px_ready(px_ready), .ram_addr(w_ram_addr), .ram_din(w_ram_din), .ram_ce(w_ce),
        .ram_oe(w_oe), .ram_we(w_we), .ram_lb(w_lb), .ram_hb(w_hb)
    );

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        if (a == 18'h00085) return 16'h0201;
        if (a[17:4] == 14'h1001) return a[0] ? 16'h4567 : 16'h0123;
        if (a < 18'h10000) return {2'b00, a[3:0] ^ 4'h5, 1'b0, a[8:0] - 9'h07D};
        return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [7:0] exp_px(input logic [17:0] mbase, input int y, input int c,
                                          input int k);
        logic [17:0] ma, ta;
        logic [15:0] e;
        logic [31:0] pat;
        int          kk;
        ma  = mbase + 18'((y / 8) * 64) + 18'(c);
        e   = mem_word(ma);
        ta  = 18'h10000 + 18'(e[8:0]) * 18'd16 + 18'(y % 8) * 18'd2;
        pat = {mem_word(ta), mem_word(ta + 18'd1)};
        kk  = k;
`ifdef BG_HFLIP_EN
        if (e[9]) kk = 7 - k;
`endif
        return {e[13:10], pat[31 - 4 * kk -: 4]};
    endfunction

    always_comb ram_din = mem_word(ram_addr);
    always_comb w_ram_din = mem_word(w_ram_addr);

    assign m_start = start & ~sel;
    assign w_start = start & sel;
    assign o_valid = sel ? w_px_valid : px_valid;
    assign o_data  = sel ? w_px_data  : px_data;
    assign o_done  = sel ? w_done     : done;
    assign o_busy  = sel ? w_busy     : busy;
    assign o_ce    = sel ? w_ce       : ram_ce;
    assign o_addr  = sel ? w_ram_addr : ram_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, px_valid, 0);
        chk({tag, "_data"}, px_data, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_ce"}, ram_ce, 0);
        chk({tag, "_oe"}, ram_oe, 0);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_lb"}, ram_lb, 1);
        chk({tag, "_hb"}, ram_hb, 1);
    endtask

    // Edge 0 launches start; the DUT samples it on edge 1. e counts edges after that.
    task automatic run_line(input logic [9:0] y, input int cols, input bit stall,
                            input int restart_e, input int abort_e,
                            output int v_e, output int d_e, output int d_n, output int post_v,
                            output logic [17:0] a1, output logic [17:0] a2,
                            output logic [17:0] a3, output logic [17:0] a12);
        bit         stalled = 0;
        bit         aborted = 0;
        logic [7:0] held = '0;
        v_e = -1; d_e = -1; d_n = 0; post_v = 0;
        a1 = '0; a2 = '0; a3 = '0; a12 = '0;
        cap_q.delete();
        @(posedge clk100); #1;
        start = 1'b1; lineY = y; px_ready = !stall;
        for (int e = 1; e <= 19 * cols + 20; e++) begin
            @(posedge clk100); #1;
            start = (e == restart_e);
            abort = (e == abort_e);
            if (stall) px_ready = stalled;
            @(negedge clk100);
            if (e == 1)  a1 = o_addr;
            if (e == 2)  a2 = o_addr;
            if (e == 3)  a3 = o_addr;
            if (e == 12) a12 = o_addr;
            if (stalled) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_data", o_data, held);
            end
            stalled = o_valid && !px_ready;
            held    = o_data;
            if (aborted && o_valid) post_v++;
            if (o_valid && v_e < 0) v_e = e;
            if (o_valid && px_ready && !abort && !aborted) cap_q.push_back(o_data);
            if (abort) aborted = 1;
            if (o_done) begin
                d_n++;
                if (d_e < 0) d_e = e;
            end
            if (d_e >= 0 && e > d_e + 2) break;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic chk_pixels(input string tag, input logic [17:0] mbase, input int y,
                              input int n);
        chk({tag, "_count"}, cap_q.size(), n);
        foreach (cap_q[i]) chk($sformatf("%s_px%0d", tag, i), cap_q[i], exp_px(mbase, y, i / 8, i % 8));
    endtask

    int          v_e, d_e, d_n, post_v;
    logic [17:0] a1, a2, a3, a12;

    initial begin
        for (int k = 0; k < 8; k++) begin
`ifdef BG_HFLIP_EN
            flip_exp[k] = 4'(7 - k);
`else
            flip_exp[k] = 4'(k);
`endif
        end
        rstN = 1'b0; start = 1'b0; abort = 1'b0; lineY = '0; px_ready = 1'b0; sel = 1'b0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk100);
        rstN = 1'b1;

        // Full line, px_ready high.
        run_line(10'd17, 40, 1'b0, 0, 0, v_e, d_e, d_n, post_v, a1, a2, a3, a12);
        chk("l1_map_addr", a1, 18'h00080);
        chk("l1_w0_addr", a2, 18'h10032);
        chk("l1_w1_addr", a3, 18'h10033);
        chk("l1_first_valid", v_e, 4);
        chk("l1_done_edge", d_e, 441);
        chk("l1_done_cnt", d_n, 1);
        chk("l1_first_px", cap_q.size() > 0 ? cap_q[0][7:4] : 4'hF, 4'h5);
        chk_pixels("l1", 18'h00000, 17, 320);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("flip%0d", k), cap_q.size() >= 48 ? cap_q[40 + k] : 8'hFF,
                {4'h0, flip_exp[k]});
        end
        chk("l1_busy_after", o_busy, 0);
        chk("l1_ce_after", o_ce, 0);

        // Stall every pixel one cycle; a start mid-line must be ignored.
        run_line(10'd17, 40, 1'b1, 100, 0, v_e, d_e, d_n, post_v, a1, a2, a3, a12);
        chk("bp_done_edge", d_e, 19 * 40 + 1);
        chk("bp_done_cnt", d_n, 1);
        chk_pixels("bp", 18'h00000, 17, 320);

        // Abort during EMIT of column 10.
        run_line(10'd17, 40, 1'b0, 0, 116, v_e, d_e, d_n, post_v, a1, a2, a3, a12);
        chk("ab_done_cnt", d_n, 0);
        chk("ab_post_valid", post_v, 0);
        chk("ab_busy", o_busy, 0);
        chk("ab_ce", o_ce, 0);
        chk_pixels("ab", 18'h00000, 17, 82);

        // Clean line after abort.
        run_line(10'd43, 40, 1'b0, 0, 0, v_e, d_e, d_n, post_v, a1, a2, a3, a12);
        chk("l2_map_addr", a1, 18'h00140);
        chk("l2_done_edge", d_e, 441);
        chk_pixels("l2", 18'h00000, 43, 320);

        // start together with abort in IDLE stays idle.
        @(posedge clk100); #1;
        start = 1'b1; abort = 1'b1; lineY = 10'd17;
        @(posedge clk100); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk100);
            chk("sa_busy", busy, 0);
            chk("sa_ce", ram_ce, 0);
            chk("sa_valid", px_valid, 0);
        end

        // Map row starting at the top of the address space wraps to 0.
        sel = 1'b1;
        run_line(10'd0, 2, 1'b0, 0, 0, v_e, d_e, d_n, post_v, a1, a2, a3, a12);
        chk("wr_first_addr", a1, 18'h3FFFF);
        chk("wr_second_addr", a12, 18'h00000);
        chk("wr_done_edge", d_e, 23);
        chk_pixels("wr", 18'h3FFFF, 0, 16);
        sel = 1'b0;

        // Asynchronous reset in the middle of column 4's pixels.
        @(posedge clk100); #1;
        start = 1'b1; lineY = 10'd17; px_ready = 1'b1;
        @(posedge clk100); #1;
        start = 1'b0;
        repeat (48) @(posedge clk100);
        #2;
        chk("mid_valid", px_valid, 1);
        chk("mid_busy", busy, 1);
        rstN = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk100);
        rstN = 1'b1;
        repeat (2) @(negedge clk100);
        chk("arst_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
